// File: rtl/free_list_pkg.sv
// Shared system sizing (physical/architectural register counts) and retire
// payload used by the rename free list.
package free_list_pkg;

    localparam int unsigned PR_NUM   = 64;
    localparam int unsigned AR_NUM   = 32;
    localparam int unsigned PR_LEN   = $clog2(PR_NUM);
    localparam int unsigned ROB_LEN  = 32;
    localparam int unsigned FL_DEPTH = PR_NUM - AR_NUM;

    typedef struct packed {
        logic              valid;
        logic              has_dest;
        logic [PR_LEN-1:0] dest_pr;
        logic [PR_LEN-1:0] stale_pr;
        logic              mispred;
    } rob_retire_packet_t;

    // Availability code: 0 = none, 1 = exactly one, 2 = two or more.
    function automatic logic [1:0] avail_code(input int unsigned cnt);
        if (cnt == 0) begin
            return 2'd0;
        end
        if (cnt == 1) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

endpackage

// File: rtl/free_list.sv
// Rename free list: circular buffer of free physical registers, two allocate
// and two free ports, recovery to the retired state. FREE_LIST_DEBUG_EN adds
// state visibility ports.
module free_list
    import free_list_pkg::*;
#(
    parameter int unsigned FL_SIZE = FL_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        alloc1_req_in,
    input  logic                        alloc2_req_in,
    output logic [PR_LEN-1:0]           alloc1_pr_out,
    output logic [PR_LEN-1:0]           alloc2_pr_out,
    output logic                        alloc1_valid_out,
    output logic                        alloc2_valid_out,
    output logic [1:0]                  avail_out,
    input  logic                        free1_valid_in,
    input  logic                        free2_valid_in,
    input  logic [PR_LEN-1:0]           free1_pr_in,
    input  logic [PR_LEN-1:0]           free2_pr_in,
    input  logic                        recover_in
`ifdef FREE_LIST_DEBUG_EN
    ,
    output logic [FL_SIZE-1:0][PR_LEN-1:0] fl_arr_out,
    output logic [$clog2(FL_SIZE)-1:0]  fl_head_out,
    output logic [$clog2(FL_SIZE)-1:0]  fl_tail_out,
    output logic [$clog2(FL_SIZE):0]    fl_count_out
`endif
);

    localparam int unsigned PTR_W = $clog2(FL_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PR_LEN-1:0] r_entry [FL_SIZE];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W-1:0]  r_arch_head;
    logic [CNT_W-1:0]  r_count;

    logic              w_grant1;
    logic              w_grant2;
    logic              w_free1_ok;
    logic              w_free2_ok;
    logic [CNT_W-1:0]  w_cnt_granted;
    logic [CNT_W-1:0]  w_cnt_freed;
    logic [PTR_W-1:0]  w_head_p1;
    logic [PTR_W-1:0]  w_tail2;
    logic [PTR_W-1:0]  w_arch_next;
    logic [PTR_W-1:0]  w_head_next;

    // Grants see only the registered count, so a PR freed this cycle is
    // not allocatable until the next one.
    always_comb begin
        w_head_p1     = r_head + PTR_W'(1);
        w_grant1      = reset && !recover_in && alloc1_req_in
                        && (r_count >= CNT_W'(1));
        w_grant2      = reset && !recover_in && alloc2_req_in
                        && (r_count >= (alloc1_req_in ? CNT_W'(2) : CNT_W'(1)));
        w_cnt_granted = r_count - CNT_W'(w_grant1) - CNT_W'(w_grant2);
        w_free1_ok    = free1_valid_in && (w_cnt_granted < CNT_W'(FL_SIZE));
        w_free2_ok    = free2_valid_in
                        && ((w_cnt_granted + CNT_W'(w_free1_ok)) < CNT_W'(FL_SIZE));
        w_cnt_freed   = w_cnt_granted + CNT_W'(w_free1_ok) + CNT_W'(w_free2_ok);
        w_tail2       = r_tail + PTR_W'(w_free1_ok);
        w_arch_next   = r_arch_head + PTR_W'(w_free1_ok) + PTR_W'(w_free2_ok);
        w_head_next   = recover_in ? w_arch_next
                                   : r_head + PTR_W'(w_grant1) + PTR_W'(w_grant2);
    end

    assign alloc1_valid_out = w_grant1;
    assign alloc2_valid_out = w_grant2;
    assign alloc1_pr_out    = r_entry[r_head];
    // A lone slot-2 request takes the head entry.
    assign alloc2_pr_out    = (alloc2_req_in && !alloc1_req_in) ? r_entry[r_head]
                                                                : r_entry[w_head_p1];
    assign avail_out        = avail_code(32'(r_count));

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FL_SIZE; i++) begin
                r_entry[i] <= PR_LEN'(FL_SIZE + i);
            end
            r_head      <= '0;
            r_tail      <= '0;
            r_arch_head <= '0;
            r_count     <= CNT_W'(FL_SIZE);
        end else begin
            if (w_free1_ok) begin
                r_entry[r_tail] <= free1_pr_in;
            end
            if (w_free2_ok) begin
                r_entry[w_tail2] <= free2_pr_in;
            end
            r_tail      <= w_tail2 + PTR_W'(w_free2_ok);
            r_arch_head <= w_arch_next;
            r_head      <= w_head_next;
            r_count     <= recover_in ? CNT_W'(FL_SIZE) : w_cnt_freed;
        end
    end

`ifdef FREE_LIST_DEBUG_EN
    always_comb begin
        for (int unsigned i = 0; i < FL_SIZE; i++) begin
            fl_arr_out[i] = r_entry[i];
        end
        fl_head_out  = r_head;
        fl_tail_out  = r_tail;
        fl_count_out = r_count;
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus randomized traffic against a
// sequence-level model of the free PR order.
module tb_free_list;
    import free_list_pkg::*;

    localparam int unsigned FL = FL_DEPTH;

    logic              clock;
    logic              reset;
    logic              alloc1_req_in;
    logic              alloc2_req_in;
    logic [PR_LEN-1:0] alloc1_pr_out;
    logic [PR_LEN-1:0] alloc2_pr_out;
    logic              alloc1_valid_out;
    logic              alloc2_valid_out;
    logic [1:0]        avail_out;
    logic              free1_valid_in;
    logic              free2_valid_in;
    logic [PR_LEN-1:0] free1_pr_in;
    logic [PR_LEN-1:0] free2_pr_in;
    logic              recover_in;

    int checks = 0;
    int errors = 0;

    // q holds every buffer slot in order starting at the allocate point;
    // the first cnt of them are the free PRs, the rest are stale slots.
    int unsigned q[$];
    int unsigned cnt;

    free_list dut (
        .clock            (clock),
        .reset            (reset),
        .alloc1_req_in    (alloc1_req_in),
        .alloc2_req_in    (alloc2_req_in),
        .alloc1_pr_out    (alloc1_pr_out),
        .alloc2_pr_out    (alloc2_pr_out),
        .alloc1_valid_out (alloc1_valid_out),
        .alloc2_valid_out (alloc2_valid_out),
        .avail_out        (avail_out),
        .free1_valid_in   (free1_valid_in),
        .free2_valid_in   (free2_valid_in),
        .free1_pr_in      (free1_pr_in),
        .free2_pr_in      (free2_pr_in),
        .recover_in       (recover_in)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void m_reset();
        q.delete();
        for (int unsigned i = 0; i < FL; i++) q.push_back(FL + i);
        cnt = FL;
    endfunction

    function automatic bit exp_g1();
        return reset && !recover_in && alloc1_req_in && (cnt >= 1);
    endfunction

    function automatic bit exp_g2();
        return reset && !recover_in && alloc2_req_in && (cnt >= (alloc1_req_in ? 2 : 1));
    endfunction

    function automatic logic [2*PR_LEN+3:0] exp_vec();
        logic [PR_LEN-1:0] p1;
        logic [PR_LEN-1:0] p2;
        logic [1:0]        av;
        p1 = PR_LEN'(q[0]);
        p2 = (alloc2_req_in && !alloc1_req_in) ? PR_LEN'(q[0]) : PR_LEN'(q[1]);
        av = (cnt == 0) ? 2'd0 : (cnt == 1) ? 2'd1 : 2'd2;
        return {exp_g1(), exp_g2(), p1, p2, av};
    endfunction

    function automatic logic [2*PR_LEN+3:0] obs_vec();
        return {alloc1_valid_out, alloc2_valid_out, alloc1_pr_out, alloc2_pr_out, avail_out};
    endfunction

    // Advance the model by the edge that follows the currently driven inputs.
    function automatic void m_commit();
        int unsigned n;
        if (!reset) begin
            m_reset();
            return;
        end
        n = 0;
        if (exp_g1()) n++;
        if (exp_g2()) n++;
        repeat (n) q.push_back(q.pop_front());
        cnt -= n;
        if (free1_valid_in && cnt < FL) begin q[cnt] = free1_pr_in; cnt++; end
        if (free2_valid_in && cnt < FL) begin q[cnt] = free2_pr_in; cnt++; end
        if (recover_in) begin
            repeat (cnt) q.push_back(q.pop_front());
            cnt = FL;
        end
    endfunction

    task automatic drive(input logic r1, input logic r2,
                         input logic f1, input logic [PR_LEN-1:0] p1,
                         input logic f2, input logic [PR_LEN-1:0] p2,
                         input logic rec, input logic rst);
        @(negedge clock);
        alloc1_req_in  = r1;
        alloc2_req_in  = r2;
        free1_valid_in = f1;
        free1_pr_in    = p1;
        free2_valid_in = f2;
        free2_pr_in    = p2;
        recover_in     = rec;
        reset          = rst;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) begin
            drive(1, 1, 1, 3, 1, 4, 1, 0);
            checks++;
            if ({alloc1_valid_out, alloc2_valid_out} !== 2'b00) begin
                errors++;
                $display("FAIL reset_valids got %b exp 00", {alloc1_valid_out, alloc2_valid_out});
            end
            m_commit();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({avail_out, alloc1_pr_out, alloc2_pr_out} !== {2'd2, PR_LEN'(32), PR_LEN'(33)}) begin
            errors++;
            $display("FAIL reset_state got av=%0d pr1=%0d pr2=%0d exp av=2 pr1=32 pr2=33",
                     avail_out, alloc1_pr_out, alloc2_pr_out);
        end
        m_commit();
    endtask

    task automatic test_exhaust();
        for (int k = 0; k < 16; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 1);
            checks++;
            if ({alloc1_valid_out, alloc2_valid_out, alloc1_pr_out, alloc2_pr_out}
                !== {2'b11, PR_LEN'(32 + 2*k), PR_LEN'(33 + 2*k)}) begin
                errors++;
                $display("FAIL exhaust_%0d got v=%b%b pr1=%0d pr2=%0d exp v=11 pr1=%0d pr2=%0d",
                         k, alloc1_valid_out, alloc2_valid_out, alloc1_pr_out, alloc2_pr_out,
                         32 + 2*k, 33 + 2*k);
            end
            m_commit();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({alloc1_valid_out, alloc2_valid_out, avail_out} !== {2'b00, 2'd0}) begin
            errors++;
            $display("FAIL exhaust_empty got v=%b%b av=%0d exp v=00 av=0",
                     alloc1_valid_out, alloc2_valid_out, avail_out);
        end
        m_commit();
    endtask

    task automatic test_free_while_empty();
        drive(1, 1, 1, 5, 1, 7, 0, 1);
        checks++;
        if ({alloc1_valid_out, alloc2_valid_out} !== 2'b00) begin
            errors++;
            $display("FAIL free_empty_nogrant got %b%b exp 00", alloc1_valid_out, alloc2_valid_out);
        end
        m_commit();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({alloc1_pr_out, alloc2_pr_out, avail_out} !== {PR_LEN'(5), PR_LEN'(7), 2'd2}) begin
            errors++;
            $display("FAIL free_empty_next got pr1=%0d pr2=%0d av=%0d exp 5 7 2",
                     alloc1_pr_out, alloc2_pr_out, avail_out);
        end
        m_commit();
    endtask

    task automatic test_single_avail();
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({alloc1_valid_out, alloc1_pr_out} !== {1'b1, PR_LEN'(5)}) begin
            errors++;
            $display("FAIL single_first got v=%b pr=%0d exp v=1 pr=5", alloc1_valid_out, alloc1_pr_out);
        end
        m_commit();
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({alloc1_valid_out, alloc2_valid_out, alloc1_pr_out, avail_out}
            !== {2'b10, PR_LEN'(7), 2'd1}) begin
            errors++;
            $display("FAIL single_only1 got v=%b%b pr1=%0d av=%0d exp v=10 pr1=7 av=1",
                     alloc1_valid_out, alloc2_valid_out, alloc1_pr_out, avail_out);
        end
        m_commit();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (avail_out !== 2'd0) begin
            errors++;
            $display("FAIL single_after got av=%0d exp 0", avail_out);
        end
        m_commit();
    endtask

    task automatic test_recover();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        m_commit();
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        m_commit();
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        m_commit();
        drive(1, 1, 1, 1, 1, 2, 1, 1);
        checks++;
        if ({alloc1_valid_out, alloc2_valid_out} !== 2'b00) begin
            errors++;
            $display("FAIL recover_suppress got %b%b exp 00", alloc1_valid_out, alloc2_valid_out);
        end
        m_commit();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({alloc1_pr_out, alloc2_pr_out, avail_out} !== {PR_LEN'(34), PR_LEN'(35), 2'd2}) begin
            errors++;
            $display("FAIL recover_state got pr1=%0d pr2=%0d av=%0d exp 34 35 2",
                     alloc1_pr_out, alloc2_pr_out, avail_out);
        end
        m_commit();
    endtask

    task automatic test_wrap_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        m_commit();
        for (int k = 0; k < 40; k++) begin
            drive(1, 1, 1, PR_LEN'($urandom), 1, PR_LEN'($urandom), 0, 1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_%0d got %h exp %h", k, obs_vec(), exp_vec());
            end
            m_commit();
        end
        drive(1, 1, 1, 9, 1, 10, 1, 0);
        checks++;
        if ({alloc1_valid_out, alloc2_valid_out} !== 2'b00) begin
            errors++;
            $display("FAIL wrap_reset_valids got %b%b exp 00", alloc1_valid_out, alloc2_valid_out);
        end
        m_commit();
        drive(0, 1, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({alloc1_pr_out, alloc2_pr_out, avail_out} !== {PR_LEN'(32), PR_LEN'(32), 2'd2}) begin
            errors++;
            $display("FAIL wrap_reset_state got pr1=%0d pr2=%0d av=%0d exp 32 32 2",
                     alloc1_pr_out, alloc2_pr_out, avail_out);
        end
        m_commit();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            drive(1'($urandom), 1'($urandom),
                  1'($urandom), PR_LEN'($urandom), 1'($urandom), PR_LEN'($urandom),
                  ($urandom_range(15) == 0), ($urandom_range(63) != 0));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d got %h exp %h", k, obs_vec(), exp_vec());
            end
            m_commit();
        end
    endtask

    initial begin
        reset          = 1'b0;
        alloc1_req_in  = 1'b0;
        alloc2_req_in  = 1'b0;
        free1_valid_in = 1'b0;
        free2_valid_in = 1'b0;
        free1_pr_in    = '0;
        free2_pr_in    = '0;
        recover_in     = 1'b0;
        m_reset();
        test_reset();
        test_exhaust();
        test_free_while_empty();
        test_single_avail();
        test_recover();
        test_wrap_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter: FL_SIZE, default 32, free-list depth = `PR_NUM - `AR_NUM (power of two).
REQ-002 Port: clock  in  1  single clock; all state updates on posedge.
REQ-003 Port: reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clock.
REQ-004 Port: alloc1_req_in, alloc2_req_in  in  1 each  dispatch slot 1/2 needs a destination PR.
REQ-005 Port: alloc1_pr_out, alloc2_pr_out  out  `PR_LEN each  PR offered to slot 1/2.
REQ-006 Port: alloc1_valid_out, alloc2_valid_out  out  1 each  grant for slot 1/2 this cycle.
REQ-007 Port: avail_out  out  2  0 = none free, 1 = one free, 2 = two or more free.
REQ-008 Port: free1_valid_in, free2_valid_in  in  1 each  ROB retire slot 1/2 retires an instruction with a destination.
REQ-009 Port: free1_pr_in, free2_pr_in  in  `PR_LEN each  stale PR released by retire slot 1/2.
REQ-010 Port: recover_in  in  1  ROB mispredict at head (OR of mispred_out1/mispred_out2).

Function
REQ-011 Storage SHALL be a circular buffer of FL_SIZE PR entries with head (allocate), tail (free), arch_head (retired-allocation) pointers of $clog2(FL_SIZE) bits and a count register of $clog2(FL_SIZE)+1 bits.
REQ-012 alloc1_pr_out SHALL equal entry[head] and alloc2_pr_out entry[head+1]; both are combinational, driven regardless of requests.
REQ-013 Grant: alloc1_valid_out = alloc1_req_in && count>=1; alloc2_valid_out = alloc2_req_in && count>=(alloc1_req_in ? 2 : 1).
REQ-014 If only alloc2_req_in is asserted, slot 2 SHALL take entry[head] (alloc2_pr_out = entry[head]).
REQ-015 At posedge, head SHALL advance by the number of grants, modulo FL_SIZE, wrapping from FL_SIZE-1 to 0.
REQ-016 Each free*_valid_in SHALL write its PR at tail (slot 1 first) and advance tail and arch_head by one each, modulo FL_SIZE.
REQ-017 Freed PRs SHALL NOT be allocatable in the same cycle (one-cycle free-to-allocate latency).
REQ-018 count_next = count - grants + frees; simultaneous grants and frees SHALL both apply.
REQ-019 recover_in SHALL suppress both grants that cycle and set head = arch_head after that cycle's frees and count = FL_SIZE.
REQ-020 A free that would make count exceed FL_SIZE is illegal; it SHALL be dropped.

Reset
REQ-021 On reset == 0 at posedge: entry[i] = FL_SIZE + i (PRs `AR_NUM..`PR_NUM-1), head = tail = arch_head = 0, count = FL_SIZE.
REQ-022 Reset SHALL override all requests, frees and recovery in the same cycle, including mid-operation.
REQ-023 During reset cycles, alloc*_valid_out SHALL be 0.
REQ-024 After reset, avail_out SHALL be 2.

Configuration
REQ-025 Macro FREE_LIST_DEBUG_EN defined: the block SHALL add outputs fl_arr_out [FL_SIZE-1:0][`PR_LEN-1:0], fl_head_out, fl_tail_out and fl_count_out for bench display.
REQ-026 Macro FREE_LIST_DEBUG_EN undefined: those ports and their logic SHALL be absent; the remaining behaviour is identical.

Structure
REQ-027 `PR_LEN, `PR_NUM, `AR_NUM, `ROB_LEN and ROB_RETIRE_PACKET SHALL come from the shared sys_defs header; FL_SIZE is derived there as `FL_SIZE.
REQ-028 The block SHALL be a single module with no sub-module; the pointer modulo arithmetic stays inline.

Verification
REQ-029 Reset scenario: release reset -> avail_out = 2, alloc1_pr_out = 32, alloc2_pr_out = 33, count = 32.
REQ-030 Exhaust scenario: two requests per cycle for 16 cycles -> PRs 32..63 granted in order; in cycle 17, valids are 0 and avail_out = 0.
REQ-031 Single-available scenario: count = 1 with both requests -> only slot 1 granted; next cycle avail_out = 0.
REQ-032 Free-while-empty scenario: free PR 5 and PR 7 with an allocation requested -> no grant that cycle; next cycle alloc1_pr_out = 5, alloc2_pr_out = 7, avail_out = 2.
REQ-033 Recover scenario: allocate 34..35 after 32..33, then retire two instructions freeing PR 1 and PR 2 with recover_in = 1 -> count = 32, alloc1_pr_out = 34, alloc2_pr_out = 35.
REQ-034 Wrap and reset scenario: cycle tail through index 31 -> 0 with correct PR order; then assert reset mid-stream -> state matches REQ-021.
